// File: rtl/display_pkg.sv
// Shared types, segment constants and width helpers for the scanned 7-segment display.
package display_pkg;

    typedef logic [3:0] bcd_t;

    // Bit positions of each segment in the 8-bit segment bus
    localparam int unsigned SEG_A  = 7;
    localparam int unsigned SEG_B  = 6;
    localparam int unsigned SEG_C  = 5;
    localparam int unsigned SEG_D  = 4;
    localparam int unsigned SEG_E  = 3;
    localparam int unsigned SEG_F  = 2;
    localparam int unsigned SEG_G  = 1;
    localparam int unsigned SEG_DP = 0;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [7:0] SEG_DASH_N = 8'hFD;

    // Bits needed to hold the number of dropped digits (at least one)
    function automatic int unsigned range_width(int unsigned n_digits, int unsigned in_digits);
        int unsigned span;
        span = in_digits - n_digits + 1;
        return (span > 1) ? 32'($clog2(span)) : 32'd1;
    endfunction

    // Bits needed to index n items (at least one)
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-high a..g decoder; non-decimal nibbles show a dash.
module bcd_to_seg
    import display_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg_c
);

    // Decode one digit, {a,b,c,d,e,f,g} with a in bit 6
    always_comb begin
        seg_c = 7'b000_0001;
        case (bcd)
            4'd0:    seg_c = 7'b111_1110;
            4'd1:    seg_c = 7'b011_0000;
            4'd2:    seg_c = 7'b110_1101;
            4'd3:    seg_c = 7'b111_1001;
            4'd4:    seg_c = 7'b011_0011;
            4'd5:    seg_c = 7'b101_1011;
            4'd6:    seg_c = 7'b101_1111;
            4'd7:    seg_c = 7'b111_0000;
            4'd8:    seg_c = 7'b111_1111;
            4'd9:    seg_c = 7'b111_1011;
            default: seg_c = 7'b000_0001;
        endcase
    end

endmodule

// File: rtl/scan_display_ctrl.sv
// Multiplexed common-anode 7-segment controller: latches a BCD value, auto-ranges
// it onto N_DIGITS digits, blanks leading zeros and shows dashes on invalid BCD.
// Optional blink support is built when DISPLAY_BLINK_EN is defined.
module scan_display_ctrl
    import display_pkg::*;
#(
    parameter int unsigned N_DIGITS  = 4,
    parameter int unsigned IN_DIGITS = 5,
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLINK_DIV = 64
) (
    input  logic                                          clk_i,
    input  logic                                          rst_n_i,
    input  logic [IN_DIGITS*4-1:0]                        bcd_i,
    input  logic                                          load_i,
    input  logic                                          blink_i,
    output logic [N_DIGITS-1:0]                           disp_en_n_o,
    output logic [7:0]                                    segment_n_o,
    output logic [range_width(N_DIGITS, IN_DIGITS)-1:0]   range_o,
    output logic                                          err_o
);

    localparam int unsigned RW = range_width(N_DIGITS, IN_DIGITS);
    localparam int unsigned DW = idx_width(N_DIGITS);
    localparam int unsigned SW = idx_width(IN_DIGITS);
    localparam int unsigned PW = idx_width(SCAN_DIV);

    bcd_t [IN_DIGITS-1:0] bcd_nib_c;
    bcd_t [IN_DIGITS-1:0] shadow_q;
    logic [RW-1:0]        range_q;
    logic                 err_q;
    logic [PW-1:0]        presc_q;
    logic [DW-1:0]        idx_q;

    int unsigned          sig_c;
    logic [RW-1:0]        new_range_c;
    logic                 new_err_c;

    logic                 presc_wrap_c;
    logic                 idx_wrap_c;

    logic [N_DIGITS-1:0]  keep_c;
    logic [SW-1:0]        sel_c;
    bcd_t                 cur_digit_c;
    logic [6:0]           seg7_c;
    logic [7:0]           seg_on_c;
    logic                 dp_c;
    logic                 blank_c;
    logic                 blink_hide_c;
    logic [N_DIGITS-1:0]  onehot_c;
    logic [N_DIGITS-1:0]  en_n_d;
    logic [7:0]           seg_n_d;

    assign bcd_nib_c = bcd_i;

    // Significant-digit count, range exponent and BCD validity of the incoming value
    always_comb begin
        sig_c       = 32'd0;
        new_err_c   = 1'b0;
        new_range_c = '0;
        for (int i = 0; i < int'(IN_DIGITS); i++) begin
            if (bcd_nib_c[i] != 4'd0) sig_c = 32'(i) + 32'd1;
            if (bcd_nib_c[i] > 4'd9)  new_err_c = 1'b1;
        end
        if (!new_err_c && (sig_c > N_DIGITS)) new_range_c = RW'(sig_c - N_DIGITS);
    end

    // Capture register: value, range and error flag all update on the load edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shadow_q <= '0;
            range_q  <= '0;
            err_q    <= 1'b0;
        end else if (load_i) begin
            shadow_q <= bcd_nib_c;
            range_q  <= new_range_c;
            err_q    <= new_err_c;
        end
    end

    assign presc_wrap_c = (presc_q == PW'(SCAN_DIV - 1));
    assign idx_wrap_c   = (idx_q == DW'(N_DIGITS - 1));

    // Digit-slot prescaler and scan index, independent of loads
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_wrap_c) begin
            presc_q <= '0;
            idx_q   <= idx_wrap_c ? '0 : idx_q + DW'(1);
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // keep_c[j]: some displayed digit at position j or above is nonzero
    always_comb begin
        logic acc;
        acc    = 1'b0;
        keep_c = '0;
        for (int j = int'(N_DIGITS) - 1; j >= 0; j--) begin
            acc       = acc | (shadow_q[SW'(32'(j) + 32'(range_q))] != 4'd0);
            keep_c[j] = acc;
        end
    end

    assign sel_c       = SW'(32'(idx_q) + 32'(range_q));
    assign cur_digit_c = shadow_q[sel_c];
    assign dp_c        = (idx_q == '0) && (range_q != '0);
    assign blank_c     = (idx_q != '0) && !keep_c[idx_q];
    assign onehot_c    = N_DIGITS'(1) << idx_q;

    bcd_to_seg u_bcd_to_seg (
        .bcd   (cur_digit_c),
        .seg_c (seg7_c)
    );

    // Place decoded segments and decimal point onto the pin order
    always_comb begin
        seg_on_c         = '0;
        seg_on_c[SEG_A]  = seg7_c[6];
        seg_on_c[SEG_B]  = seg7_c[5];
        seg_on_c[SEG_C]  = seg7_c[4];
        seg_on_c[SEG_D]  = seg7_c[3];
        seg_on_c[SEG_E]  = seg7_c[2];
        seg_on_c[SEG_F]  = seg7_c[1];
        seg_on_c[SEG_G]  = seg7_c[0];
        seg_on_c[SEG_DP] = dp_c;
    end

`ifdef DISPLAY_BLINK_EN
    localparam int unsigned FW = idx_width(2 * BLINK_DIV);

    logic [FW-1:0] frame_q;

    // Frame counter advancing each time the scan returns to digit 0
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frame_q <= '0;
        end else if (presc_wrap_c && idx_wrap_c) begin
            frame_q <= (frame_q == FW'(2 * BLINK_DIV - 1)) ? '0 : frame_q + FW'(1);
        end
    end

    assign blink_hide_c = blink_i && (32'(frame_q) >= BLINK_DIV);
`else
    logic blink_unused;

    assign blink_unused = blink_i & (BLINK_DIV != 0);
    assign blink_hide_c = 1'b0;
`endif

    // Next pin state for the current slot: error dashes, blanking, or the digit
    always_comb begin
        en_n_d  = '1;
        seg_n_d = SEG_BLANK;
        if (err_q) begin
            en_n_d  = ~onehot_c;
            seg_n_d = SEG_DASH_N;
        end else if (!blank_c) begin
            en_n_d  = ~onehot_c;
            seg_n_d = ~seg_on_c;
        end
        if (blink_hide_c) begin
            en_n_d  = '1;
            seg_n_d = SEG_BLANK;
        end
    end

    // Registered pin drivers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            disp_en_n_o <= '1;
            segment_n_o <= SEG_BLANK;
        end else begin
            disp_en_n_o <= en_n_d;
            segment_n_o <= seg_n_d;
        end
    end

    assign range_o = range_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Scoreboard bench for scan_display_ctrl (4 digits, 6 input digits, 4 clocks/slot).
module tb_scan_display_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned IN = 6;
    localparam int unsigned SD = 4;
    localparam int unsigned BD = 2;

    logic        clk_i   = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [23:0] bcd_i   = '0;
    logic        load_i  = 1'b0;
    logic        blink_i = 1'b0;
    logic [3:0]  disp_en_n_o;
    logic [7:0]  segment_n_o;
    logic [1:0]  range_o;
    logic        err_o;

    scan_display_ctrl #(
        .N_DIGITS  (N),
        .IN_DIGITS (IN),
        .SCAN_DIV  (SD),
        .BLINK_DIV (BD)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .bcd_i       (bcd_i),
        .load_i      (load_i),
        .blink_i     (blink_i),
        .disp_en_n_o (disp_en_n_o),
        .segment_n_o (segment_n_o),
        .range_o     (range_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Per-slot expected pins, index [s] = slot s
    typedef struct packed {
        logic [3:0][3:0] en;
        logic [3:0][7:0] seg;
    } tbl_t;

    typedef struct {
        int         cyc;
        logic [3:0] en;
        logic [7:0] seg;
        logic [1:0] rng;
        logic       err;
        string      tag;
    } exp_t;

    localparam tbl_t T_ZERO   = {16'hFFFE, 32'hFFFF_FF03};
    localparam tbl_t T_42     = {16'hFFDE, 32'hFFFF_9925};
    localparam tbl_t T_123456 = {16'h7BDE, 32'h9F25_0D98};
    localparam tbl_t T_098760 = {16'h7BDE, 32'h0901_1F40};
    localparam tbl_t T_001020 = {16'h7BDE, 32'h9F03_2503};
    localparam tbl_t T_ERR    = {16'h7BDE, 32'hFDFD_FDFD};
    localparam tbl_t T_1      = {16'hFFFE, 32'hFFFF_FF9F};

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   base  = 4;
    tbl_t prev;

    function automatic int slot_at(int c);
        return ((c - base) / int'(SD)) % int'(N);
    endfunction

    task automatic push(int c, logic [3:0] en, logic [7:0] seg, logic [1:0] rng, logic err, string tag);
        exp_t e;
        e.cyc = c; e.en = en; e.seg = seg; e.rng = rng; e.err = err; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic push_tbl(int c, tbl_t t, logic [1:0] rng, logic err, string tag);
        int s;
        s = slot_at(c);
        push(c, t.en[s], t.seg[s], rng, err, tag);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) tick();
    endtask

    // One load pulse: capture edge shows new range/err with old segments, then a full new frame
    task automatic do_load(logic [23:0] v, tbl_t t, logic [1:0] rng, logic err, string tag);
        int c;
        c      = cyc;
        bcd_i  = v;
        load_i = 1'b1;
        push_tbl(c + 1, prev, rng, err, {tag, "_cap"});
        for (int k = 2; k <= 17; k++) push_tbl(c + k, t, rng, err, tag);
        tick();
        load_i = 1'b0;
        prev   = t;
        wait_cyc(c + 17);
    endtask

    // Monitor: compare DUT pins against every expectation due this cycle
    always @(negedge clk_i) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_vec++;
            if (e.cyc != cyc) begin
                n_err++;
                $display("FAIL %s cyc %0d: expectation not sampled in time (now cyc %0d)", e.tag, e.cyc, cyc);
            end else if ({disp_en_n_o, segment_n_o, range_o, err_o} !== {e.en, e.seg, e.rng, e.err}) begin
                n_err++;
                $display("FAIL %s cyc %0d: got en=%h seg=%h rng=%0d err=%b, want en=%h seg=%h rng=%0d err=%b",
                         e.tag, cyc, disp_en_n_o, segment_n_o, range_o, err_o, e.en, e.seg, e.rng, e.err);
            end
        end
        if (cyc > 3000) begin
            $display("FAIL watchdog: run exceeded cycle budget, %0d vectors applied, %0d miscompares", n_vec, n_err + 1);
            $fatal(1, "watchdog");
        end
    end

    initial begin
        prev = T_ZERO;
        for (int c = 1; c <= 3; c++) push(c, 4'hF, 8'hFF, 2'd0, 1'b0, "in_reset");
        wait_cyc(3);
        rst_n_i = 1'b1;
        base    = 4;
        for (int k = 4; k <= 19; k++) push_tbl(k, T_ZERO, 2'd0, 1'b0, "idle_zero");
        wait_cyc(19);

        do_load(24'h000042, T_42,     2'd0, 1'b0, "ld000042");
        do_load(24'h123456, T_123456, 2'd2, 1'b0, "ld123456");
        do_load(24'h098760, T_098760, 2'd1, 1'b0, "ld098760");
        do_load(24'h001020, T_001020, 2'd0, 1'b0, "ld001020");
        do_load(24'h00A001, T_ERR,    2'd0, 1'b1, "ld00A001");
        do_load(24'h000001, T_1,      2'd0, 1'b0, "ld000001");
        do_load(24'hF00000, T_ERR,    2'd0, 1'b1, "ldF00000");

        // Align so the load is sampled with the prescaler at 2
        while (((cyc - base) % int'(SD)) != 1) tick();
        do_load(24'h123456, T_123456, 2'd2, 1'b0, "midslot");

        // Asynchronous reset in the middle of a frame
        tick();
        rst_n_i = 1'b0;
        push(cyc,     4'hF, 8'hFF, 2'd0, 1'b0, "rst_async");
        push(cyc + 1, 4'hF, 8'hFF, 2'd0, 1'b0, "rst_held");
        tick();
        rst_n_i = 1'b1;
        base    = cyc + 1;
        for (int k = base; k <= base + 15; k++) push_tbl(k, T_ZERO, 2'd0, 1'b0, "post_rst");
        wait_cyc(base + 15);

        // Blink request: hidden only during frames 2..3 and only when the feature is built
        blink_i = 1'b1;
        for (int k = base + 16; k <= base + 79; k++) begin
`ifdef DISPLAY_BLINK_EN
            if (k >= base + 32 && k <= base + 40) push(k, 4'hF, 8'hFF, 2'd0, 1'b0, "blink_hidden");
            else push_tbl(k, T_ZERO, 2'd0, 1'b0, "blink_shown");
`else
            push_tbl(k, T_ZERO, 2'd0, 1'b0, "blink_ignored");
`endif
        end
        wait_cyc(base + 40);
        blink_i = 1'b0;
        wait_cyc(base + 79);
        @(negedge clk_i);
        #1;

        if (q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got %0d unchecked expectations, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
